// File: rtl/lpm_tbl_access_ctrl.sv
// Sequencer sharing the LPM route table port between host single ops and a bulk-clear walk.
// One table op in flight at a time; a missing ack aborts the op after ACK_TIMEOUT cycles.
module lpm_tbl_access_ctrl #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned TBL_DEPTH   = 32,
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '1
) (
    input  logic                  AXI_ACLK,
    input  logic                  reset,
    input  logic                  host_rd_req,
    input  logic                  host_wr_req,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  host_busy,
    output logic                  host_done,
    output logic                  host_err,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  tbl_rd_req,
    output logic                  tbl_wr_req,
    output logic [ADDR_WIDTH-1:0] tbl_rd_addr,
    output logic [ADDR_WIDTH-1:0] tbl_wr_addr,
    output logic [DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                  tbl_rd_ack,
    input  logic                  tbl_wr_ack,
    output logic [31:0]           timeout_count
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_REQ,
        S_HOST_WAIT,
        S_CLR_REQ,
        S_CLR_WAIT
    } state_t;

    state_t                  state;
    logic                    pend_wr;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [DATA_WIDTH-1:0]   pend_data;
    logic [CNT_W-1:0]        wait_cnt;
    logic [ADDR_WIDTH-1:0]   clr_ptr;

    logic                    host_cap_c;
    logic                    clr_cap_c;
    logic                    timeout_c;
    logic                    last_entry_c;
    logic                    host_is_wr_c;
    logic [ADDR_WIDTH-1:0]   host_addr_c;
    logic [DATA_WIDTH-1:0]   host_data_c;
    logic [31:0]             timeout_inc_c;

    assign host_cap_c    = !host_busy && (host_rd_req || host_wr_req);
    assign clr_cap_c     = !clr_busy && clr_start;
    assign timeout_c     = (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign last_entry_c  = (clr_ptr == ADDR_WIDTH'(TBL_DEPTH - 1));
    assign timeout_inc_c = (timeout_count == 32'hFFFF_FFFF) ? timeout_count : timeout_count + 32'd1;

    // In IDLE a request arriving this cycle is issued directly, otherwise the latched one
    assign host_is_wr_c = host_busy ? pend_wr   : host_wr_req;
    assign host_addr_c  = host_busy ? pend_addr : host_addr;
    assign host_data_c  = host_busy ? pend_data : host_wr_data;

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state         <= S_IDLE;
            pend_wr       <= 1'b0;
            pend_addr     <= '0;
            pend_data     <= '0;
            wait_cnt      <= '0;
            clr_ptr       <= '0;
            host_rd_data  <= '0;
            host_busy     <= 1'b0;
            host_done     <= 1'b0;
            host_err      <= 1'b0;
            clr_busy      <= 1'b0;
            clr_done      <= 1'b0;
            tbl_rd_req    <= 1'b0;
            tbl_wr_req    <= 1'b0;
            tbl_rd_addr   <= '0;
            tbl_wr_addr   <= '0;
            tbl_wr_data   <= '0;
            timeout_count <= '0;
        end else begin
            host_done  <= 1'b0;
            host_err   <= 1'b0;
            clr_done   <= 1'b0;
            tbl_rd_req <= 1'b0;
            tbl_wr_req <= 1'b0;

            if (host_cap_c) begin
                host_busy <= 1'b1;
                pend_wr   <= host_wr_req;
                pend_addr <= host_addr;
                pend_data <= host_wr_data;
            end
            if (clr_cap_c) begin
                clr_busy <= 1'b1;
                clr_ptr  <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (host_busy || host_cap_c) begin
                        state <= S_HOST_REQ;
                        if (host_is_wr_c) begin
                            tbl_wr_req  <= 1'b1;
                            tbl_wr_addr <= host_addr_c;
                            tbl_wr_data <= host_data_c;
                        end else begin
                            tbl_rd_req  <= 1'b1;
                            tbl_rd_addr <= host_addr_c;
                        end
                    end else if (clr_busy || clr_cap_c) begin
                        state       <= S_CLR_REQ;
                        tbl_wr_req  <= 1'b1;
                        tbl_wr_addr <= clr_busy ? clr_ptr : '0;
                        tbl_wr_data <= CLEAR_VALUE;
                    end
                end
                S_HOST_REQ: begin
                    state    <= S_HOST_WAIT;
                    wait_cnt <= '0;
                end
                S_HOST_WAIT: begin
                    if (pend_wr ? tbl_wr_ack : tbl_rd_ack) begin
                        if (!pend_wr) begin
                            host_rd_data <= tbl_rd_data;
                        end
                        host_done <= 1'b1;
                        host_busy <= 1'b0;
                        state     <= S_IDLE;
                    end else if (timeout_c) begin
                        host_done     <= 1'b1;
                        host_err      <= 1'b1;
                        host_busy     <= 1'b0;
                        timeout_count <= timeout_inc_c;
                        state         <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_CLR_REQ: begin
                    state    <= S_CLR_WAIT;
                    wait_cnt <= '0;
                end
                S_CLR_WAIT: begin
                    // A timed-out entry is skipped; the walk always advances
                    if (tbl_wr_ack || timeout_c) begin
                        if (!tbl_wr_ack) begin
                            timeout_count <= timeout_inc_c;
                        end
                        if (last_entry_c) begin
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end else begin
                            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
                        end
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
